// File: rtl/dest_ip_table_arbiter_pkg.sv
// Shared constants, FSM state type and parity helper for the destination-IP table.
// Optional parity storage is enabled with DEST_IP_TBL_PARITY_EN.
package dest_ip_table_arbiter_pkg;

    localparam int DIT_DATA_WIDTH   = 32;
    localparam int DIT_ADDR_WIDTH   = 5;
    localparam int DIT_DEPTH        = 32;
    localparam int DIT_STARVE_LIMIT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } lkp_state_e;

    function automatic logic even_par(input logic [DIT_DATA_WIDTH-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/dest_ip_table_arbiter_if.sv
// Host register and lookup-engine signals of the destination-IP table.
// master = requester side (register block / parser), slave = table arbiter.
interface dest_ip_table_arbiter_if #(
    parameter int DW = dest_ip_table_arbiter_pkg::DIT_DATA_WIDTH,
    parameter int AW = dest_ip_table_arbiter_pkg::DIT_ADDR_WIDTH
);
    logic          host_rd_req;
    logic [AW-1:0] host_rd_addr;
    logic [DW-1:0] host_rd_data;
    logic          host_rd_ack;
    logic          host_wr_req;
    logic [AW-1:0] host_wr_addr;
    logic [DW-1:0] host_wr_data;
    logic          host_wr_ack;
    logic          lkp_req;
    logic [DW-1:0] lkp_key;
    logic          lkp_busy;
    logic          lkp_done;
    logic          lkp_hit;
    logic [AW-1:0] lkp_index;
    logic [31:0]   host_stall_count;
    logic          parity_err;

    modport master (
        output host_rd_req, host_rd_addr,
        output host_wr_req, host_wr_addr, host_wr_data,
        output lkp_req, lkp_key,
        input  host_rd_data, host_rd_ack, host_wr_ack,
        input  lkp_busy, lkp_done, lkp_hit, lkp_index,
        input  host_stall_count, parity_err
    );

    modport slave (
        input  host_rd_req, host_rd_addr,
        input  host_wr_req, host_wr_addr, host_wr_data,
        input  lkp_req, lkp_key,
        output host_rd_data, host_rd_ack, host_wr_ack,
        output lkp_busy, lkp_done, lkp_hit, lkp_index,
        output host_stall_count, parity_err
    );
endinterface

// File: rtl/dest_ip_table_mem.sv
// Single-port LUTRAM for the destination-IP table: async read, sync write.
// Contents have no reset so entries survive a datapath reset.
module dest_ip_table_mem #(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 32
) (
    input  logic             AXI_ACLK,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] ram [DEPTH];

    always_ff @(posedge AXI_ACLK) begin
        if (we) begin
            ram[addr] <= wdata;
        end
    end

    assign rdata = ram[addr];
endmodule

// File: rtl/dest_ip_table_arbiter.sv
// Destination-IP table owner: host/lookup port arbitration, scan FSM, starvation guard.
// Define DEST_IP_TBL_PARITY_EN to store and check an even-parity bit per entry.
module dest_ip_table_arbiter
    import dest_ip_table_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = DIT_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DIT_ADDR_WIDTH,
    parameter int DEPTH        = DIT_DEPTH,
    parameter int STARVE_LIMIT = DIT_STARVE_LIMIT
) (
    input logic AXI_ACLK,
    input logic reset,
    dest_ip_table_arbiter_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam int AW = ADDR_WIDTH;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
`ifdef DEST_IP_TBL_PARITY_EN
    localparam int MW = DW + 1;
`else
    localparam int MW = DW;
`endif

    lkp_state_e    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] index_q, index_d;
    logic          hit_q, hit_d;
    logic [DW-1:0] key_q;

    logic          rd_pend_q, wr_pend_q;
    logic [AW-1:0] rd_addr_q, wr_addr_q;
    logic [DW-1:0] wr_data_q;
    logic [SW-1:0] starve_q;
    logic [31:0]   stall_q;
    logic          rd_ack_q, wr_ack_q;
    logic [DW-1:0] rd_data_q;

    logic          host_pend, host_grant;
    logic          wr_grant, rd_grant, scan_grant;
    logic [AW-1:0] mem_addr;
    logic [MW-1:0] mem_wdata, mem_rdata;
    logic [DW-1:0] entry;
    logic          ent_perr;
    logic          match;

    assign host_pend  = rd_pend_q | wr_pend_q;
    assign host_grant = host_pend &&
                        (state_q != SCAN || starve_q == SW'(STARVE_LIMIT));
    assign wr_grant   = host_grant & wr_pend_q;
    assign rd_grant   = host_grant & ~wr_pend_q & rd_pend_q;
    assign scan_grant = (state_q == SCAN) & ~host_grant;

    always_comb begin
        mem_addr = idx_q;
        if (wr_grant) begin
            mem_addr = wr_addr_q;
        end else if (rd_grant) begin
            mem_addr = rd_addr_q;
        end
    end

    assign entry = mem_rdata[DW-1:0];

`ifdef DEST_IP_TBL_PARITY_EN
    assign mem_wdata = {even_par(wr_data_q), wr_data_q};
    assign ent_perr  = ^mem_rdata;
`else
    assign mem_wdata = wr_data_q;
    assign ent_perr  = 1'b0;
`endif

    assign match = (entry == key_q) && (entry != '0) && !ent_perr;

    dest_ip_table_mem #(
        .WIDTH (MW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_mem (
        .AXI_ACLK (AXI_ACLK),
        .we       (wr_grant),
        .addr     (mem_addr),
        .wdata    (mem_wdata),
        .rdata    (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hit_d   = 1'b0;
        index_d = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.lkp_req) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                // ungranted cycles hold idx so no entry is skipped
                if (scan_grant) begin
                    if (match) begin
                        state_d = DONE;
                        hit_d   = 1'b1;
                        index_d = idx_q;
                    end else if (idx_q == AW'(DEPTH - 1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge AXI_ACLK) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hit_q   <= 1'b0;
            index_q <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hit_q   <= hit_d;
            index_q <= index_d;
            if (state_q == IDLE && bus.lkp_req) begin
                key_q <= bus.lkp_key;
            end
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (reset) begin
            rd_pend_q <= 1'b0;
            wr_pend_q <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            starve_q  <= '0;
            stall_q   <= '0;
            rd_ack_q  <= 1'b0;
            wr_ack_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            // a request arriving while its flag is set is dropped
            rd_pend_q <= (rd_pend_q & ~rd_grant) | (bus.host_rd_req & ~rd_pend_q);
            wr_pend_q <= (wr_pend_q & ~wr_grant) | (bus.host_wr_req & ~wr_pend_q);
            if (bus.host_rd_req && !rd_pend_q) begin
                rd_addr_q <= bus.host_rd_addr;
            end
            if (bus.host_wr_req && !wr_pend_q) begin
                wr_addr_q <= bus.host_wr_addr;
                wr_data_q <= bus.host_wr_data;
            end
            if (host_grant) begin
                starve_q <= '0;
            end else if (scan_grant && host_pend && starve_q != SW'(STARVE_LIMIT)) begin
                starve_q <= starve_q + 1'b1;
            end
            if (host_pend && !host_grant) begin
                stall_q <= stall_q + 32'd1;
            end
            rd_ack_q <= rd_grant;
            wr_ack_q <= wr_grant;
            if (rd_grant) begin
                rd_data_q <= entry;
            end
        end
    end

`ifdef DEST_IP_TBL_PARITY_EN
    logic perr_q;

    always_ff @(posedge AXI_ACLK) begin
        if (reset) begin
            perr_q <= 1'b0;
        end else if ((rd_grant || scan_grant) && ent_perr) begin
            perr_q <= 1'b1;
        end
    end

    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.host_rd_data     = rd_data_q;
    assign bus.host_rd_ack      = rd_ack_q;
    assign bus.host_wr_ack      = wr_ack_q;
    assign bus.lkp_busy         = (state_q != IDLE);
    assign bus.lkp_done         = (state_q == DONE);
    assign bus.lkp_hit          = hit_q;
    assign bus.lkp_index        = index_q;
    assign bus.host_stall_count = stall_q;
endmodule

// File: tb/tb_dest_ip_table_arbiter.sv
// Directed bench for dest_ip_table_arbiter: vector table plus
// starvation, write-during-scan, dual-request and mid-scan reset sequences.
module tb_dest_ip_table_arbiter;
    import dest_ip_table_arbiter_pkg::*;

    logic AXI_ACLK = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    dest_ip_table_arbiter_if bus ();

    dest_ip_table_arbiter dut (
        .AXI_ACLK (AXI_ACLK),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 AXI_ACLK = ~AXI_ACLK;

    typedef enum logic [1:0] {OP_WR, OP_RD, OP_LK} op_e;

    typedef struct {
        op_e         op;
        logic [4:0]  addr;
        logic [31:0] data;
        int          lat;
        logic        hit;
        logic [4:0]  idx;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge AXI_ACLK);
        #1;
    endtask

    task automatic host_wr(input logic [4:0] a, input logic [31:0] d, output int lat);
        bus.host_wr_req  = 1'b1;
        bus.host_wr_addr = a;
        bus.host_wr_data = d;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            bus.host_wr_req = 1'b0;
            if (bus.host_wr_ack) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic host_rd(input logic [4:0] a, output int lat, output logic [31:0] d);
        bus.host_rd_req  = 1'b1;
        bus.host_rd_addr = a;
        lat = 0;
        d   = '0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            bus.host_rd_req = 1'b0;
            if (bus.host_rd_ack) begin
                lat = c;
                d   = bus.host_rd_data;
                break;
            end
        end
    endtask

    task automatic lookup(input logic [31:0] k, output int lat,
                          output logic h, output logic [4:0] ix);
        bus.lkp_req = 1'b1;
        bus.lkp_key = k;
        lat = 0;
        h   = 1'b0;
        ix  = '0;
        for (int c = 1; c <= 80; c++) begin
            tick();
            bus.lkp_req = 1'b0;
            if (bus.lkp_done) begin
                lat = c;
                h   = bus.lkp_hit;
                ix  = bus.lkp_index;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] d;
        logic        h;
        logic [4:0]  ix;
        int          rd_c, wr_c, done_c, n_rd, n_wr, n_done;
        logic [31:0] rdd;
        logic [31:0] stall0;

        bus.host_rd_req  = 1'b0;
        bus.host_rd_addr = '0;
        bus.host_wr_req  = 1'b0;
        bus.host_wr_addr = '0;
        bus.host_wr_data = '0;
        bus.lkp_req      = 1'b0;
        bus.lkp_key      = '0;
        reset            = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        chk("rst_busy", 64'(bus.lkp_busy), 64'd0);
        chk("rst_done", 64'(bus.lkp_done), 64'd0);
        chk("rst_hit", 64'(bus.lkp_hit), 64'd0);
        chk("rst_index", 64'(bus.lkp_index), 64'd0);
        chk("rst_rd_ack", 64'(bus.host_rd_ack), 64'd0);
        chk("rst_wr_ack", 64'(bus.host_wr_ack), 64'd0);
        chk("rst_rd_data", 64'(bus.host_rd_data), 64'd0);
        chk("rst_stall", 64'(bus.host_stall_count), 64'd0);
        chk("rst_perr", 64'(bus.parity_err), 64'd0);

        for (int i = 0; i < 32; i++) begin
            host_wr(5'(i), 32'd0, lat);
            chk("clr_wr_lat", 64'(lat), 64'd2);
        end

        vecs.push_back('{OP_WR, 5'd3,  32'h0A000001, 2,  1'b0, 5'd0});
        vecs.push_back('{OP_RD, 5'd3,  32'h0A000001, 2,  1'b0, 5'd0});
        vecs.push_back('{OP_WR, 5'd3,  32'h0A000003, 2,  1'b0, 5'd0});
        vecs.push_back('{OP_WR, 5'd5,  32'h0A000001, 2,  1'b0, 5'd0});
        vecs.push_back('{OP_LK, 5'd0,  32'h0A000001, 7,  1'b1, 5'd5});
        vecs.push_back('{OP_LK, 5'd0,  32'h0A000003, 5,  1'b1, 5'd3});
        vecs.push_back('{OP_LK, 5'd0,  32'hC0A80101, 33, 1'b0, 5'd0});
        vecs.push_back('{OP_LK, 5'd0,  32'h00000000, 33, 1'b0, 5'd0});
        vecs.push_back('{OP_WR, 5'd0,  32'h01020304, 2,  1'b0, 5'd0});
        vecs.push_back('{OP_LK, 5'd0,  32'h01020304, 2,  1'b1, 5'd0});
        vecs.push_back('{OP_WR, 5'd31, 32'hFFFFFFFF, 2,  1'b0, 5'd0});
        vecs.push_back('{OP_LK, 5'd0,  32'hFFFFFFFF, 33, 1'b1, 5'd31});
        vecs.push_back('{OP_RD, 5'd31, 32'hFFFFFFFF, 2,  1'b0, 5'd0});
        vecs.push_back('{OP_RD, 5'd7,  32'h00000000, 2,  1'b0, 5'd0});

        foreach (vecs[i]) begin
            unique case (vecs[i].op)
                OP_WR: begin
                    host_wr(vecs[i].addr, vecs[i].data, lat);
                    chk("vec_wr_lat", 64'(lat), 64'(vecs[i].lat));
                end
                OP_RD: begin
                    host_rd(vecs[i].addr, lat, d);
                    chk("vec_rd_lat", 64'(lat), 64'(vecs[i].lat));
                    chk("vec_rd_data", 64'(d), 64'(vecs[i].data));
                end
                default: begin
                    lookup(vecs[i].data, lat, h, ix);
                    chk("vec_lk_lat", 64'(lat), 64'(vecs[i].lat));
                    chk("vec_lk_hit", 64'(h), 64'(vecs[i].hit));
                    chk("vec_lk_idx", 64'(ix), 64'(vecs[i].idx));
                    tick();
                    chk("vec_lk_busy_off", 64'(bus.lkp_busy), 64'd0);
                end
            endcase
        end

        // starvation: miss scan with a host read arriving at cycle 2
        stall0 = bus.host_stall_count;
        bus.lkp_req = 1'b1;
        bus.lkp_key = 32'hC0A80101;
        rd_c = 0; done_c = 0; n_rd = 0; rdd = '0; h = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            bus.lkp_req      = 1'b0;
            bus.host_rd_req  = (c == 2);
            bus.host_rd_addr = 5'd3;
            if (bus.host_rd_ack) begin
                n_rd++;
                if (rd_c == 0) begin
                    rd_c = c;
                    rdd  = bus.host_rd_data;
                end
            end
            if (bus.lkp_done && done_c == 0) begin
                done_c = c;
                h      = bus.lkp_hit;
            end
        end
        chk("starve_rd_cycle", 64'(rd_c), 64'd12);
        chk("starve_rd_data", 64'(rdd), 64'h0A000003);
        chk("starve_rd_count", 64'(n_rd), 64'd1);
        chk("starve_done_cycle", 64'(done_c), 64'd34);
        chk("starve_hit", 64'(h), 64'd0);
        chk("starve_stall", 64'(bus.host_stall_count - stall0), 64'd8);

        // write during a scan lands ahead of the scan pointer
        stall0 = bus.host_stall_count;
        bus.lkp_req = 1'b1;
        bus.lkp_key = 32'h55555555;
        wr_c = 0; done_c = 0; h = 1'b0; ix = '0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            bus.lkp_req      = 1'b0;
            bus.host_wr_req  = (c == 1);
            bus.host_wr_addr = 5'd20;
            bus.host_wr_data = 32'h55555555;
            if (bus.host_wr_ack && wr_c == 0) wr_c = c;
            if (bus.lkp_done && done_c == 0) begin
                done_c = c;
                h      = bus.lkp_hit;
                ix     = bus.lkp_index;
            end
        end
        chk("wscan_wr_cycle", 64'(wr_c), 64'd11);
        chk("wscan_done_cycle", 64'(done_c), 64'd23);
        chk("wscan_hit", 64'(h), 64'd1);
        chk("wscan_idx", 64'(ix), 64'd20);
        chk("wscan_stall", 64'(bus.host_stall_count - stall0), 64'd8);

        // same-cycle rd+wr while idle, then a dropped second read
        bus.host_rd_req  = 1'b1;
        bus.host_rd_addr = 5'd5;
        bus.host_wr_req  = 1'b1;
        bus.host_wr_addr = 5'd9;
        bus.host_wr_data = 32'h0B0B0B0B;
        rd_c = 0; wr_c = 0; n_rd = 0; n_wr = 0; rdd = '0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            bus.host_wr_req  = 1'b0;
            bus.host_rd_req  = (c == 1);
            bus.host_rd_addr = (c == 1) ? 5'd6 : 5'd5;
            if (bus.host_wr_ack) begin
                n_wr++;
                if (wr_c == 0) wr_c = c;
            end
            if (bus.host_rd_ack) begin
                n_rd++;
                if (rd_c == 0) begin
                    rd_c = c;
                    rdd  = bus.host_rd_data;
                end
            end
        end
        chk("dual_wr_cycle", 64'(wr_c), 64'd2);
        chk("dual_rd_cycle", 64'(rd_c), 64'd3);
        chk("dual_rd_data", 64'(rdd), 64'h0A000001);
        chk("dual_rd_count", 64'(n_rd), 64'd1);
        chk("dual_wr_count", 64'(n_wr), 64'd1);
        host_rd(5'd9, lat, d);
        chk("dual_wr_readback", 64'(d), 64'h0B0B0B0B);

        // reset mid-scan with a host read pending
        bus.lkp_req = 1'b1;
        bus.lkp_key = 32'hC0A80101;
        for (int c = 1; c <= 5; c++) begin
            tick();
            bus.lkp_req      = 1'b0;
            bus.host_rd_req  = (c == 4);
            bus.host_rd_addr = 5'd3;
        end
        chk("mid_busy_before", 64'(bus.lkp_busy), 64'd1);
        bus.host_rd_req = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_busy_after", 64'(bus.lkp_busy), 64'd0);
        chk("mid_stall_after", 64'(bus.host_stall_count), 64'd0);
        n_done = 0; n_rd = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.lkp_done) n_done++;
            if (bus.host_rd_ack) n_rd++;
            tick();
        end
        chk("mid_no_done", 64'(n_done), 64'd0);
        chk("mid_no_rd_ack", 64'(n_rd), 64'd0);
        host_rd(5'd3, lat, d);
        chk("mid_keep_idx3", 64'(d), 64'h0A000003);
        host_rd(5'd20, lat, d);
        chk("mid_keep_idx20", 64'(d), 64'h55555555);
        chk("final_perr", 64'(bus.parity_err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
